// File: rtl/kernel_mem_responder_pkg.sv
// Shared types and helpers for the kernel array memory responder.
package kmem_pkg;

  typedef enum logic [0:0] {
    H_IDLE = 1'b0,
    H_RD   = 1'b1
  } host_state_e;

  localparam int RD_LAT_MAX = 4;

  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/kernel_mem_responder_if.sv
// Kernel array port and host request/response port of the memory responder.
interface kernel_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] k_address0;
  logic              k_ce0;
  logic              k_we0;
  logic [DATA_W-1:0] k_ad0;
  logic [DATA_W-1:0] k_q0;
  logic              h_valid;
  logic              h_ready;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;
  logic              oor_err;

  modport master (
    output k_address0, k_ce0, k_we0, k_ad0, h_valid, h_we, h_addr, h_wdata,
    input  k_q0, h_ready, h_rvalid, h_rdata, oor_err
  );

  modport slave (
    input  k_address0, k_ce0, k_we0, k_ad0, h_valid, h_we, h_addr, h_wdata,
    output k_q0, h_ready, h_rvalid, h_rdata, oor_err
  );
endinterface

// File: rtl/kernel_mem_responder_rd_pipe.sv
// RD_LAT-deep read delay line; the last data stage holds until the next read completes.
module kmem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] vld_r;
  logic [DATA_W-1:0] dat_r [RD_LAT];

  // Data stages only advance behind a valid, so idle cycles never disturb the held result
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_r[i] <= '0;
    end else begin
      vld_r[0] <= in_valid;
      if (in_valid) dat_r[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[RD_LAT-1];
  assign out_data  = dat_r[RD_LAT-1];

endmodule

// File: rtl/kernel_mem_responder.sv
// Single-port memory behind the HLS kernel array interface with a host preload/inspect port.
// Optional MEM_STATS_EN adds saturating kernel read/write counters stat_rd/stat_wr.
module kernel_mem_responder
  import kmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  kernel_mem_responder_if.slave  bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]            stat_rd,
  output logic [31:0]            stat_wr
`endif
);

  localparam int LAT   = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  host_state_e       state_r;
  logic [2:0]        cnt_r;
  logic              oor_r;

  logic              k_rd_s, k_wr_s, k_oor_s;
  logic              h_ready_s, h_acc_s, h_rd_s, h_wr_s, h_oor_s;
  logic [DATA_W-1:0] k_rdata_s, h_rdata_s;
  logic              k_rvalid_unused_s;

  // Request decode and read-first array lookup (out-of-range reads return zero)
  always_comb begin
    k_oor_s   = !addr_in_range(64'(bus.k_address0), 64'(DEPTH));
    h_oor_s   = !addr_in_range(64'(bus.h_addr), 64'(DEPTH));
    k_rd_s    = bus.k_ce0 && !bus.k_we0;
    k_wr_s    = bus.k_ce0 && bus.k_we0;
    h_ready_s = (state_r == H_IDLE) && !bus.k_ce0;
    h_acc_s   = bus.h_valid && h_ready_s;
    h_rd_s    = h_acc_s && !bus.h_we;
    h_wr_s    = h_acc_s && bus.h_we;
    k_rdata_s = '0;
    h_rdata_s = '0;
    if (!k_oor_s) k_rdata_s = mem_r[bus.k_address0[IDX_W-1:0]];
    else          k_rdata_s = '0;
    if (!h_oor_s) h_rdata_s = mem_r[bus.h_addr[IDX_W-1:0]];
    else          h_rdata_s = '0;
  end

  // Storage is deliberately not reset; host can only write when the kernel is idle
  always_ff @(posedge sys_clk) begin
    if (k_wr_s && !k_oor_s)      mem_r[bus.k_address0[IDX_W-1:0]] <= bus.k_ad0;
    else if (h_wr_s && !h_oor_s) mem_r[bus.h_addr[IDX_W-1:0]]     <= bus.h_wdata;
  end

  // Host FSM: one outstanding read, released on the cycle its response pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= H_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      case (state_r)
        H_IDLE: begin
          if (h_rd_s) begin
            state_r <= H_RD;
            cnt_r   <= 3'd1;
          end
        end
        H_RD: begin
          if (cnt_r == 3'(LAT)) begin
            state_r <= H_IDLE;
            cnt_r   <= 3'd0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= H_IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

  // Sticky out-of-range flag
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) oor_r <= 1'b0;
    else if ((bus.k_ce0 && k_oor_s) || (h_acc_s && h_oor_s)) oor_r <= 1'b1;
  end

  kmem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_k_pipe (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (k_rd_s),
    .in_data   (k_rdata_s),
    .out_valid (k_rvalid_unused_s),
    .out_data  (bus.k_q0)
  );

  kmem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_h_pipe (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (h_rd_s),
    .in_data   (h_rdata_s),
    .out_valid (bus.h_rvalid),
    .out_data  (bus.h_rdata)
  );

  assign bus.h_ready = h_ready_s;
  assign bus.oor_err = oor_r;

`ifdef MEM_STATS_EN
  logic [31:0] stat_rd_r, stat_wr_r;

  // Saturating counters of accepted kernel accesses, including out-of-range ones
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_rd_r <= 32'd0;
      stat_wr_r <= 32'd0;
    end else begin
      if (k_rd_s && (stat_rd_r != 32'hFFFF_FFFF)) stat_rd_r <= stat_rd_r + 32'd1;
      if (k_wr_s && (stat_wr_r != 32'hFFFF_FFFF)) stat_wr_r <= stat_wr_r + 32'd1;
    end
  end

  assign stat_rd = stat_rd_r;
  assign stat_wr = stat_wr_r;
`endif

endmodule

// File: tb/tb_kernel_mem_responder.sv
// Directed bench: two responders (RD_LAT 1 and 2) driven by identical stimulus.
module tb_kernel_mem_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        k_ce, k_we, h_valid, h_we;
  logic [31:0] k_addr, k_ad, h_addr, h_wdata;
  int          checks = 0;
  int          failures = 0;

  always #5 sys_clk = ~sys_clk;

  kernel_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) if1 (), if2 ();

  assign if1.k_address0 = k_addr;  assign if2.k_address0 = k_addr;
  assign if1.k_ce0      = k_ce;    assign if2.k_ce0      = k_ce;
  assign if1.k_we0      = k_we;    assign if2.k_we0      = k_we;
  assign if1.k_ad0      = k_ad;    assign if2.k_ad0      = k_ad;
  assign if1.h_valid    = h_valid; assign if2.h_valid    = h_valid;
  assign if1.h_we       = h_we;    assign if2.h_we       = h_we;
  assign if1.h_addr     = h_addr;  assign if2.h_addr     = h_addr;
  assign if1.h_wdata    = h_wdata; assign if2.h_wdata    = h_wdata;

`ifdef MEM_STATS_EN
  logic [31:0] s1_rd, s1_wr, s2_rd, s2_wr;
`endif

  kernel_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(1)) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if1)
`ifdef MEM_STATS_EN
    , .stat_rd (s1_rd), .stat_wr (s1_wr)
`endif
  );

  kernel_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(2)) dut2 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if2)
`ifdef MEM_STATS_EN
    , .stat_rd (s2_rd), .stat_wr (s2_wr)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!if1.h_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("host_wait_bound", 32'(n < 50), 32'd1);
  endtask

  task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
    h_valid = 1'b1; h_we = 1'b1; h_addr = addr; h_wdata = data;
    wait_ready();
    tick();
    h_valid = 1'b0; h_we = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp, input logic [31:0] kq_exp);
    h_valid = 1'b1; h_we = 1'b0; h_addr = addr;
    wait_ready();
    tick();
    h_valid = 1'b0;
    check_eq({tag, "_rvalid1"}, 32'(if1.h_rvalid), 32'd1);
    check_eq({tag, "_rdata1"}, if1.h_rdata, exp);
    check_eq({tag, "_rvalid2_early"}, 32'(if2.h_rvalid), 32'd0);
    tick();
    check_eq({tag, "_rvalid1_pulse"}, 32'(if1.h_rvalid), 32'd0);
    check_eq({tag, "_rvalid2"}, 32'(if2.h_rvalid), 32'd1);
    check_eq({tag, "_rdata2"}, if2.h_rdata, exp);
    check_eq({tag, "_kq_undisturbed"}, if1.k_q0, kq_exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    k_ce = 1'b0; k_we = 1'b0; k_addr = 32'd0; k_ad = 32'd0;
    h_valid = 1'b0; h_we = 1'b0; h_addr = 32'd0; h_wdata = 32'd0;
    repeat (3) tick();
    check_eq("rst_kq1", if1.k_q0, 32'd0);
    check_eq("rst_kq2", if2.k_q0, 32'd0);
    check_eq("rst_rvalid", 32'(if1.h_rvalid), 32'd0);
    check_eq("rst_rdata", if1.h_rdata, 32'd0);
    check_eq("rst_oor", 32'(if1.oor_err), 32'd0);
    sys_rst = 1'b0;
    tick();
    check_eq("idle_ready", 32'(if1.h_ready), 32'd1);

    // Host preload then pipelined kernel reads
    for (int i = 0; i < 8; i++) host_write(32'(i), 32'(32'h100 + i));
    for (int i = 0; i < 8; i++) begin
      k_ce = 1'b1; k_we = 1'b0; k_addr = 32'(i);
      tick();
      check_eq("krd_lat1", if1.k_q0, 32'(32'h100 + i));
      check_eq("krd_lat2", if2.k_q0, (i == 0) ? 32'd0 : 32'(32'h100 + i - 1));
    end
    k_ce = 1'b0;
    tick();
    check_eq("krd_lat2_last", if2.k_q0, 32'h107);
    check_eq("kq_hold", if1.k_q0, 32'h107);

    host_read("hrd5", 32'd5, 32'h105, 32'h107);

    // Kernel activity blocks the host
    k_ce = 1'b1; k_we = 1'b0; k_addr = 32'd0;
    h_valid = 1'b1; h_we = 1'b1; h_addr = 32'd10; h_wdata = 32'h5A5;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("busy_ready_low", 32'(if1.h_ready), 32'd0);
      tick();
    end
    k_ce = 1'b0;
    #1;
    check_eq("ready_after_kernel", 32'(if1.h_ready), 32'd1);
    tick();
    h_valid = 1'b0; h_we = 1'b0;
    k_ce = 1'b1; k_addr = 32'd10;
    tick();
    check_eq("host_wr_visible", if1.k_q0, 32'h5A5);

    // Read, write, read of the same word
    k_we = 1'b1; k_addr = 32'd3; k_ad = 32'h55;
    tick();
    k_we = 1'b0;
    tick();
    check_eq("rw_old1", if1.k_q0, 32'h55);
    k_we = 1'b1; k_ad = 32'hAA;
    tick();
    check_eq("rw_hold1", if1.k_q0, 32'h55);
    check_eq("rw_old2", if2.k_q0, 32'h55);
    k_we = 1'b0;
    tick();
    check_eq("rw_new1", if1.k_q0, 32'hAA);
    check_eq("rw_hold2", if2.k_q0, 32'h55);
    k_ce = 1'b0;
    tick();
    check_eq("rw_new2", if2.k_q0, 32'hAA);

    // Out-of-range accesses
    check_eq("oor_clear", 32'(if1.oor_err), 32'd0);
    host_write(32'd44, 32'h44);
    k_ce = 1'b1; k_we = 1'b0; k_addr = 32'd256;
    tick();
    check_eq("oor_rd_zero", if1.k_q0, 32'd0);
    check_eq("oor_set", 32'(if1.oor_err), 32'd1);
    k_we = 1'b1; k_addr = 32'd300; k_ad = 32'hDEAD;
    tick();
    k_addr = 32'd261; k_ad = 32'hBEEF;
    tick();
    k_we = 1'b0; k_addr = 32'd44;
    tick();
    check_eq("oor_wr300_ignored", if1.k_q0, 32'h44);
    k_addr = 32'd5;
    tick();
    check_eq("oor_wr261_ignored", if1.k_q0, 32'h105);
    k_ce = 1'b0;
    host_read("hrd_oor", 32'd256, 32'd0, 32'h105);
    check_eq("oor_sticky", 32'(if1.oor_err), 32'd1);

    // Reset while a host read is in flight
    h_valid = 1'b1; h_we = 1'b0; h_addr = 32'd7;
    wait_ready();
    tick();
    h_valid = 1'b0;
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rst_drop_rvalid2", 32'(if2.h_rvalid), 32'd0);
      check_eq("rst_drop_rvalid1", 32'(if1.h_rvalid), 32'd0);
      tick();
    end
    check_eq("rst_mid_kq1", if1.k_q0, 32'd0);
    check_eq("rst_mid_kq2", if2.k_q0, 32'd0);
    check_eq("rst_mid_oor", 32'(if1.oor_err), 32'd0);
    sys_rst = 1'b0;
    tick();
    check_eq("rst_mid_ready", 32'(if1.h_ready), 32'd1);
    k_ce = 1'b1; k_we = 1'b0; k_addr = 32'd7;
    tick();
    check_eq("mem_kept", if1.k_q0, 32'h107);

    // Access counts since reset: 10 reads, 4 writes (one out of range)
    for (int i = 0; i < 9; i++) begin
      k_addr = 32'(i);
      tick();
    end
    k_we = 1'b1;
    k_addr = 32'd200; k_ad = 32'h200; tick();
    k_addr = 32'd201; k_ad = 32'h201; tick();
    k_addr = 32'd202; k_ad = 32'h202; tick();
    k_addr = 32'd400; k_ad = 32'h400; tick();
    k_ce = 1'b0; k_we = 1'b0;
    tick();
    check_eq("oor_after_rst", 32'(if1.oor_err), 32'd1);
`ifdef MEM_STATS_EN
    check_eq("stat_rd1", s1_rd, 32'd10);
    check_eq("stat_wr1", s1_wr, 32'd4);
    check_eq("stat_rd2", s2_rd, 32'd10);
    check_eq("stat_wr2", s2_wr, 32'd4);
`endif
    k_ce = 1'b1; k_addr = 32'd201;
    tick();
    check_eq("wr201", if1.k_q0, 32'h201);
    k_ce = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
